gbpt_gen2: RTL
==============

GBPT_GEN2 -- requirements
Module: gbpt_gen2

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- GBPT_SETS, 512, number of sets; power of two.
- GBPT_ENTRIES_PER_BLOCK, 8, counters per set; power of two.
- CTR_WIDTH, 2, saturating counter width; range 2..4.
- INIT_CTR, 2**(CTR_WIDTH-1)-1, counter value written by the init sweep (weakly not-taken).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK  in  1  clock; one clock.
- nRST  in  1  reset; synchronous, active-low.
- valid_RESP  in  1  prediction lookup request.
- full_PC_RESP  in  32  lookup PC.
- GH_RESP  in  GH_LENGTH  lookup global history.
- ASID_RESP  in  ASID_WIDTH  lookup ASID.
- pred_taken_RESTART  out  1  prediction, one cycle after valid_RESP.
- update0_valid  in  1  update request.
- update0_start_full_PC  in  32  update PC.
- update0_GH  in  GH_LENGTH  update history.
- update0_ASID  in  ASID_WIDTH  update ASID.
- update0_taken  in  1  resolved direction.
- update1_correct  out  1  old prediction matched update1_taken.
- init_done  out  1  table sweep complete; table usable.

Function
REQ-003 The hash SHALL be W = log2(SETS)+log2(EPB) bits: PC[W:1] XOR GH[W-1:0] XOR ASID. GH and ASID are zero-extended or truncated to W. The upper log2(SETS) bits are the set index; the lower bits are the entry.
REQ-004 FSM states SHALL be INIT and READY. Reset enters INIT with sweep counter 0.
REQ-005 In INIT, each cycle SHALL write INIT_CTR to all entries of set[counter] and then increment the counter. After writing set SETS-1 the FSM moves to READY, and init_done rises the following cycle. The sweep takes exactly SETS cycles.
REQ-006 In INIT, valid_RESP and update0_valid SHALL be ignored: no read, no write, pred_taken_RESTART=0, update1_correct=0.
REQ-007 In READY, pred_taken_RESTART SHALL be the MSB of the selected counter, one cycle after valid_RESP. It SHALL be 0 if valid_RESP was low the prior cycle.
REQ-008 The update pipeline SHALL be as follows. Update0 reads the set. Update1, one cycle later, computes the new counter and writes the whole set. The new counter saturates: +1 if taken (ceiling 2**CTR_WIDTH-1), -1 if not taken (floor 0). The other entries of the set are unchanged.
REQ-009 update1_correct SHALL equal update1_valid AND (old counter MSB == update1_taken). The old counter includes any forwarded value.
REQ-010 Back-to-back updates to the same set SHALL forward. If the update1 write set equals the set read by update0 in the same cycle, the next update1 uses the registered written set data instead of RAM data.
REQ-011 Predictions SHALL bypass in-flight writes. If the RESP read set equals the update1 write set in the same cycle, pred_taken_RESTART uses the new written data.
REQ-012 Simultaneous RESP read and update0 read SHALL both be serviced every cycle, with no stall.
REQ-013 Read-after-reset SHALL return only swept data. The table contents before the sweep are undefined and never observed.

Reset
REQ-014 On nRST low at a CLK edge, the block SHALL set the FSM to INIT and the sweep counter to 0. It SHALL clear init_done, update1 valid and the forward/bypass flags. pred_taken_RESTART and update1_correct SHALL read 0 the next cycle.
REQ-015 Reset mid-sweep or mid-update SHALL restart the sweep from set 0. Any in-flight update is discarded.
REQ-016 The RAM contents themselves SHALL NOT be reset; the sweep initialises them.

Structure
REQ-017 GH_LENGTH and ASID_WIDTH SHALL come from core_types_pkg. The default GBPT_* values SHALL live in core_types_pkg as GBPT2_* constants.
REQ-018 Storage SHALL be bram_2rport_1wport with INNER_WIDTH = EPB*CTR_WIDTH and OUTER_WIDTH = SETS. The write port is muxed between the sweep and update1.
REQ-019 One sub-module, gbpt_gen2_index_hash, parametrised on W, SHALL be instantiated twice: once for RESP and once for update0.

Verification (SETS=16, EPB=4, CTR_WIDTH=3, INIT_CTR=3)
REQ-020 Scenarios SHALL include:
- Release nRST. init_done rises at cycle 17. Lookups during the sweep give pred 0. A lookup after the sweep gives pred 0, since the counter is 3.
- Three consecutive taken updates to the same entry. The counter goes 3->4->5->6 via forwarding. update1_correct goes 0,1,1.
- Nine taken updates hold the counter at 7. Nine not-taken updates then hold it at 0. Predictions read 1, then 0.
- Counter at 3, then one taken update. A lookup of the same set in the cycle of the update1 write returns pred 1 (bypass).
- Assert nRST at sweep cycle 5 for one cycle. init_done rises 17 cycles after release.
- Back-to-back updates to entries 0 and 2 of one set, both taken. Both counters read 4. Entries 1 and 3 remain 3.

Source files
------------

// File: rtl/core_types_pkg.sv
// Core-wide widths and default predictor geometry.
// The history and ASID widths are shared by every predictor that hashes on them.
package core_types_pkg;

  localparam int GH_LENGTH               = 8;
  localparam int ASID_WIDTH              = 9;
  localparam int GBPT2_SETS              = 512;
  localparam int GBPT2_ENTRIES_PER_BLOCK = 8;
  localparam int GBPT2_CTR_WIDTH         = 2;

endpackage

// File: rtl/gbpt_gen2_pkg.sv
// Types local to the gen2 global branch prediction table.
package gbpt_gen2_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } gbpt_state_e;

endpackage

// File: rtl/gbpt_gen2_if.sv
// Lookup / update / status bundle between the front end and the gen2 GBPT.
interface gbpt_gen2_if;
  import core_types_pkg::*;

  logic                  valid_RESP;
  logic [31:0]           full_PC_RESP;
  logic [GH_LENGTH-1:0]  GH_RESP;
  logic [ASID_WIDTH-1:0] ASID_RESP;
  logic                  pred_taken_RESTART;

  logic                  update0_valid;
  logic [31:0]           update0_start_full_PC;
  logic [GH_LENGTH-1:0]  update0_GH;
  logic [ASID_WIDTH-1:0] update0_ASID;
  logic                  update0_taken;
  logic                  update1_correct;

  logic                  init_done;

  modport master (
    output valid_RESP, full_PC_RESP, GH_RESP, ASID_RESP,
    output update0_valid, update0_start_full_PC, update0_GH, update0_ASID, update0_taken,
    input  pred_taken_RESTART, update1_correct, init_done
  );

  modport slave (
    input  valid_RESP, full_PC_RESP, GH_RESP, ASID_RESP,
    input  update0_valid, update0_start_full_PC, update0_GH, update0_ASID, update0_taken,
    output pred_taken_RESTART, update1_correct, init_done
  );

endinterface

// File: rtl/bram_2rport_1wport.sv
// Block RAM with two synchronous read ports and one write port.
// A read of the address being written in the same cycle returns the old contents.
module bram_2rport_1wport #(
  parameter int INNER_WIDTH = 16,
  parameter int OUTER_WIDTH = 512
) (
  input  logic                           CLK,
  input  logic                           port0_ren,
  input  logic [$clog2(OUTER_WIDTH)-1:0] port0_rindex,
  output logic [INNER_WIDTH-1:0]         port0_rdata,
  input  logic                           port1_ren,
  input  logic [$clog2(OUTER_WIDTH)-1:0] port1_rindex,
  output logic [INNER_WIDTH-1:0]         port1_rdata,
  input  logic                           wen,
  input  logic [$clog2(OUTER_WIDTH)-1:0] windex,
  input  logic [INNER_WIDTH-1:0]         wdata
);

  logic [INNER_WIDTH-1:0] mem [OUTER_WIDTH];

  always_ff @(posedge CLK) begin
    if (wen)       mem[windex]  <= wdata;
    if (port0_ren) port0_rdata <= mem[port0_rindex];
    if (port1_ren) port1_rdata <= mem[port1_rindex];
  end

endmodule

// File: rtl/gbpt_gen2_index_hash.sv
// Table index hash: PC[W:1] ^ GH ^ ASID, with GH and ASID fitted to W bits.
module gbpt_gen2_index_hash
  import core_types_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [31:0]           full_PC,
  input  logic [GH_LENGTH-1:0]  GH,
  input  logic [ASID_WIDTH-1:0] ASID,
  output logic [W-1:0]          index
);

  logic [W-1:0] gh_w;
  logic [W-1:0] asid_w;
  logic         unused_hash_bits;

  always_comb begin
    gh_w   = '0;
    asid_w = '0;
    for (int unsigned i = 0; i < W && i < GH_LENGTH; i++)  gh_w[i]   = GH[i];
    for (int unsigned i = 0; i < W && i < ASID_WIDTH; i++) asid_w[i] = ASID[i];
  end

  assign index            = full_PC[W:1] ^ gh_w ^ asid_w;
  assign unused_hash_bits = ^{full_PC, GH, ASID};

endmodule

// File: rtl/gbpt_gen2.sv
// Gen2 global branch prediction table: set-organised saturating counters with an
// init sweep, a two-stage update pipeline, update forwarding and lookup bypass.
module gbpt_gen2
  import core_types_pkg::*;
  import gbpt_gen2_pkg::*;
#(
  parameter int GBPT_SETS              = GBPT2_SETS,
  parameter int GBPT_ENTRIES_PER_BLOCK = GBPT2_ENTRIES_PER_BLOCK,
  parameter int CTR_WIDTH              = GBPT2_CTR_WIDTH,
  parameter int INIT_CTR               = 2**(CTR_WIDTH-1)-1
) (
  input logic        CLK,
  input logic        nRST,
  gbpt_gen2_if.slave bp
);

  localparam int SET_BITS   = $clog2(GBPT_SETS);
  localparam int ENTRY_BITS = $clog2(GBPT_ENTRIES_PER_BLOCK);
  localparam int W          = SET_BITS + ENTRY_BITS;
  localparam int SET_WIDTH  = GBPT_ENTRIES_PER_BLOCK * CTR_WIDTH;

  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(INIT_CTR);
  localparam logic [SET_BITS-1:0]  LAST_SET = SET_BITS'(GBPT_SETS - 1);

  gbpt_state_e state, next_state;
  logic [SET_BITS-1:0] sweep_set;
  logic                sweep_wen;
  logic                ready;
  logic                init_done_q;

  logic [W-1:0]          resp_hash, upd_hash;
  logic [SET_BITS-1:0]   resp_set, upd0_set;
  logic [ENTRY_BITS-1:0] resp_entry, upd0_entry;
  logic                  resp_ren, upd0_ren;

  logic [SET_WIDTH-1:0] ram_resp_rdata, ram_upd_rdata;
  logic                 ram_wen;
  logic [SET_BITS-1:0]  ram_windex;
  logic [SET_WIDTH-1:0] ram_wdata;

  logic                  resp_valid_q, resp_bypass_q;
  logic [ENTRY_BITS-1:0] resp_entry_q;
  logic                  upd1_valid, upd1_taken, upd1_fwd_q;
  logic [SET_BITS-1:0]   upd1_set;
  logic [ENTRY_BITS-1:0] upd1_entry;
  logic [SET_WIDTH-1:0]  last_wdata_q;

  logic [SET_WIDTH-1:0] upd1_old_set, upd1_new_set, resp_data;
  logic [CTR_WIDTH-1:0] upd1_old_ctr, upd1_new_ctr;
  logic                 resp_msb;

  // FSM state register and sweep counter
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= INIT;
      sweep_set <= '0;
    end else begin
      state <= next_state;
      if (sweep_wen) sweep_set <= sweep_set + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (sweep_set == LAST_SET) next_state = READY;
      READY:   next_state = READY;
      default: next_state = INIT;
    endcase
  end

  always_comb begin
    sweep_wen = (state == INIT);
    ready     = (state == READY);
  end

  gbpt_gen2_index_hash #(.W(W)) u_resp_hash (
    .full_PC (bp.full_PC_RESP),
    .GH      (bp.GH_RESP),
    .ASID    (bp.ASID_RESP),
    .index   (resp_hash)
  );

  gbpt_gen2_index_hash #(.W(W)) u_upd_hash (
    .full_PC (bp.update0_start_full_PC),
    .GH      (bp.update0_GH),
    .ASID    (bp.update0_ASID),
    .index   (upd_hash)
  );

  assign resp_set   = resp_hash[W-1 -: SET_BITS];
  assign resp_entry = resp_hash[ENTRY_BITS-1:0];
  assign upd0_set   = upd_hash[W-1 -: SET_BITS];
  assign upd0_entry = upd_hash[ENTRY_BITS-1:0];
  assign resp_ren   = ready && bp.valid_RESP;
  assign upd0_ren   = ready && bp.update0_valid;

  // Sweep owns the write port during INIT; update1 can only be live in READY.
  assign ram_wen    = sweep_wen || upd1_valid;
  assign ram_windex = sweep_wen ? sweep_set : upd1_set;
  assign ram_wdata  = sweep_wen ? {GBPT_ENTRIES_PER_BLOCK{CTR_INIT}} : upd1_new_set;

  bram_2rport_1wport #(
    .INNER_WIDTH (SET_WIDTH),
    .OUTER_WIDTH (GBPT_SETS)
  ) u_table (
    .CLK          (CLK),
    .port0_ren    (resp_ren),
    .port0_rindex (resp_set),
    .port0_rdata  (ram_resp_rdata),
    .port1_ren    (upd0_ren),
    .port1_rindex (upd0_set),
    .port1_rdata  (ram_upd_rdata),
    .wen          (ram_wen),
    .windex       (ram_windex),
    .wdata        (ram_wdata)
  );

  // The RAM returns pre-write data on a same-cycle collision, so both read
  // paths remember whether they must take the just-written set instead.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      resp_valid_q  <= 1'b0;
      resp_bypass_q <= 1'b0;
      upd1_valid    <= 1'b0;
      upd1_fwd_q    <= 1'b0;
      init_done_q   <= 1'b0;
    end else begin
      resp_valid_q  <= resp_ren;
      resp_bypass_q <= resp_ren && upd1_valid && (resp_set == upd1_set);
      upd1_valid    <= upd0_ren;
      upd1_fwd_q    <= upd0_ren && upd1_valid && (upd0_set == upd1_set);
      init_done_q   <= ready;
    end
  end

  always_ff @(posedge CLK) begin
    resp_entry_q <= resp_entry;
    upd1_set     <= upd0_set;
    upd1_entry   <= upd0_entry;
    upd1_taken   <= bp.update0_taken;
    if (upd1_valid) last_wdata_q <= upd1_new_set;
  end

  always_comb begin
    upd1_old_set = upd1_fwd_q ? last_wdata_q : ram_upd_rdata;
    upd1_old_ctr = '0;
    for (int unsigned e = 0; e < GBPT_ENTRIES_PER_BLOCK; e++)
      if (upd1_entry == ENTRY_BITS'(e)) upd1_old_ctr = upd1_old_set[e*CTR_WIDTH +: CTR_WIDTH];

    if (upd1_taken) upd1_new_ctr = (upd1_old_ctr == CTR_MAX) ? upd1_old_ctr : upd1_old_ctr + 1'b1;
    else            upd1_new_ctr = (upd1_old_ctr == '0)      ? upd1_old_ctr : upd1_old_ctr - 1'b1;

    upd1_new_set = upd1_old_set;
    for (int unsigned e = 0; e < GBPT_ENTRIES_PER_BLOCK; e++)
      if (upd1_entry == ENTRY_BITS'(e)) upd1_new_set[e*CTR_WIDTH +: CTR_WIDTH] = upd1_new_ctr;
  end

  always_comb begin
    resp_data = resp_bypass_q ? last_wdata_q : ram_resp_rdata;
    resp_msb  = 1'b0;
    for (int unsigned e = 0; e < GBPT_ENTRIES_PER_BLOCK; e++)
      if (resp_entry_q == ENTRY_BITS'(e)) resp_msb = resp_data[e*CTR_WIDTH + CTR_WIDTH - 1];
  end

  assign bp.pred_taken_RESTART = resp_valid_q && resp_msb;
  assign bp.update1_correct    = upd1_valid && (upd1_old_ctr[CTR_WIDTH-1] == upd1_taken);
  assign bp.init_done          = init_done_q;

endmodule
